// File: rtl/fft_output_reorder.sv
// Bit-reversed to natural-order reorder buffer for an 8-point FFT.
// Ping-pong banks: one fills from the butterfly while the other streams out.
module fft_output_reorder #(
    parameter int CW    = 25,
    parameter int LOG2N = 3,
    parameter int SHIFT = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [2*CW-1:0]     in_data_i,
    input  logic [LOG2N-1:0]    in_idx_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [2*CW-1:0]     out_data_o,
    output logic [LOG2N-1:0]    out_idx_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                out_last_o,
    output logic [7:0]          frame_cnt_o,
    output logic                seq_err_o,
    input  logic                clr_err_i
);

    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    logic [2*CW-1:0]  mem [2][N];
    state_t           state, state_nxt;
    logic             wb, rb, wb_nxt;
    logic [1:0]       full, full_nxt;
    logic [LOG2N-1:0] wr_cnt, rd_cnt;
    logic             wr_en, wr_last, rd_fire, rd_done;

    assign wr_en   = in_valid_i && in_ready_o;
    assign wr_last = wr_en && (wr_cnt == LAST);
    assign rd_fire = (state == STREAM) && out_ready_i;
    assign rd_done = rd_fire && (rd_cnt == LAST);

    // Set and clear can land on the same edge; they always target different banks.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        full_nxt = full;
        if (wr_last) full_nxt[wb] = 1'b1;
        if (rd_done) full_nxt[rb] = 1'b0;
        wb_nxt = wb ^ wr_last;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (full[rb]) state_nxt = STREAM;
            STREAM:  if (rd_done && !full[~rb]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sample storage is not reset; clearing the full flags is what discards a frame.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wb][bitrev(in_idx_i)] <= in_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            wb          <= 1'b0;
            rb          <= 1'b0;
            full        <= 2'b00;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            in_ready_o  <= 1'b1;
            frame_cnt_o <= 8'd0;
            seq_err_o   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            state      <= state_nxt;
            full       <= full_nxt;
            wb         <= wb_nxt;
            in_ready_o <= !full_nxt[wb_nxt];
            if (wr_en) wr_cnt <= wr_cnt + 1'b1;
            if (rd_fire) rd_cnt <= rd_cnt + 1'b1;
            if (rd_done) begin
                rb          <= ~rb;
                frame_cnt_o <= frame_cnt_o + 8'd1;
            end
            if (wr_en && (in_idx_i != wr_cnt)) seq_err_o <= 1'b1;
            else if (clr_err_i)                seq_err_o <= 1'b0;
        end
    end

    logic [2*CW-1:0]     rd_word;
    logic signed [CW-1:0] rd_re, rd_im, sc_re, sc_im;

    assign rd_word = mem[rb][rd_cnt];
    assign rd_re   = rd_word[2*CW-1:CW];
    assign rd_im   = rd_word[CW-1:0];
    assign sc_re   = rd_re >>> SHIFT;
    assign sc_im   = rd_im >>> SHIFT;

    // Data is forced to zero outside STREAM so reset shows a clean bus.
    assign out_valid_o = (state == STREAM);
    assign out_idx_o   = rd_cnt;
    assign out_last_o  = out_valid_o && (rd_cnt == LAST);
    assign out_data_o  = out_valid_o ? {sc_re, sc_im} : '0;

endmodule

// File: tb/tb_fft_output_reorder.sv
// Randomized bench for fft_output_reorder: a frame-level bit-reverse model
// predicts every output bin; two instances cover SHIFT=0 and SHIFT=2.
module tb_fft_output_reorder;

    localparam int CW = 25;
    localparam int W  = 2 * CW;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [W-1:0]  in_data_i = '0;
    logic [2:0]    in_idx_i = '0;
    logic          in_valid_i = 1'b0;
    logic          out_ready_i = 1'b0;
    logic          clr_err_i = 1'b0;

    logic          in_ready_o, out_valid_o, out_last_o, seq_err_o;
    logic [W-1:0]  out_data_o;
    logic [2:0]    out_idx_o;
    logic [7:0]    frame_cnt_o;

    logic          in_ready1, out_valid1, out_last1, seq_err1;
    logic [W-1:0]  out_data1;
    logic [2:0]    out_idx1;
    logic [7:0]    frame_cnt1;

    fft_output_reorder #(.CW(CW), .LOG2N(3), .SHIFT(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_data_i(in_data_i), .in_idx_i(in_idx_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .out_data_o(out_data_o),
        .out_idx_o(out_idx_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_last_o(out_last_o), .frame_cnt_o(frame_cnt_o), .seq_err_o(seq_err_o),
        .clr_err_i(clr_err_i));

    fft_output_reorder #(.CW(CW), .LOG2N(3), .SHIFT(2)) dut_sh (
        .clk_i(clk_i), .rst_i(rst_i), .in_data_i(in_data_i), .in_idx_i(in_idx_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready1), .out_data_o(out_data1),
        .out_idx_o(out_idx1), .out_valid_o(out_valid1), .out_ready_i(out_ready_i),
        .out_last_o(out_last1), .frame_cnt_o(frame_cnt1), .seq_err_o(seq_err1),
        .clr_err_i(clr_err_i));

    initial forever #5 clk_i = ~clk_i;

    typedef struct { logic [2:0] idx; logic [W-1:0] d0; logic [W-1:0] d1; logic last; int cyc; } obs_t;
    typedef struct { logic [W-1:0] d0; logic [W-1:0] d1; } exp_t;

    obs_t         obs_q[$];
    exp_t         exp_q[$];
    logic [W-1:0] cur [8];
    int           wcnt, cyc, stall_bad, stall_seen, ctrl_diff;
    int           checks = 0;
    int           errors = 0;
    int           ready_mode = 0;   // 0 hold low, 1 hold high, 2 random

    logic [2:0]   fr_idx [8];
    logic [W-1:0] fr_dat [8];

    function automatic int rev3(input int v);
        return ((v & 1) << 2) | (v & 2) | ((v >> 2) & 1);
    endfunction

    function automatic logic [W-1:0] scale2(input logic [W-1:0] d);
        logic signed [CW-1:0] re, im;
        re = d[W-1:CW];
        im = d[CW-1:0];
        re = re >>> 2;
        im = im >>> 2;
        return {re, im};
    endfunction

    function automatic logic [W-1:0] rnd_word();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    // Reference model: a frame is a set of (index, sample) pairs; bin k of the
    // output is the sample whose index bit-reverses to k.
    initial begin : monitor
        exp_t e;
        obs_t o;
        logic          prev_stall;
        logic [W-1:0]  p_d0, p_d1;
        logic [2:0]    p_idx;
        logic          p_last;
        prev_stall = 1'b0;
        p_d0 = '0; p_d1 = '0; p_idx = '0; p_last = 1'b0;
        wcnt = 0; cyc = 0; stall_bad = 0; stall_seen = 0; ctrl_diff = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                wcnt = 0;
                exp_q.delete();
                obs_q.delete();
                prev_stall = 1'b0;
            end else begin
                cyc++;
                if (in_valid_i && in_ready_o) begin
                    cur[rev3(int'(in_idx_i))] = in_data_i;
                    wcnt++;
                    if (wcnt == 8) begin
                        for (int k = 0; k < 8; k++) begin
                            e.d0 = cur[k];
                            e.d1 = scale2(cur[k]);
                            exp_q.push_back(e);
                        end
                        wcnt = 0;
                    end
                end
                if (prev_stall) begin
                    stall_seen++;
                    if (out_data_o !== p_d0 || out_data1 !== p_d1 || out_idx_o !== p_idx ||
                        out_last_o !== p_last || out_valid_o !== 1'b1)
                        stall_bad++;
                end
                if (in_ready1 !== in_ready_o || out_valid1 !== out_valid_o || out_idx1 !== out_idx_o ||
                    out_last1 !== out_last_o || frame_cnt1 !== frame_cnt_o || seq_err1 !== seq_err_o)
                    ctrl_diff++;
                if (out_valid_o && out_ready_i) begin
                    o.idx = out_idx_o; o.d0 = out_data_o; o.d1 = out_data1;
                    o.last = out_last_o; o.cyc = cyc;
                    obs_q.push_back(o);
                end
                prev_stall = out_valid_o && !out_ready_i;
                p_d0 = out_data_o; p_d1 = out_data1; p_idx = out_idx_o; p_last = out_last_o;
            end
        end
    end

    initial begin : ready_drv
        forever begin
            @(posedge clk_i);
            #2;
            case (ready_mode)
                0:       out_ready_i = 1'b0;
                1:       out_ready_i = 1'b1;
                default: out_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    // Presents one sample and returns just after the edge that accepts it.
    task automatic send_sample(input logic [2:0] idx, input logic [W-1:0] data);
        logic r;
        int   n;
        in_valid_i = 1'b1;
        in_idx_i   = idx;
        in_data_i  = data;
        n = 0;
        forever begin
            @(negedge clk_i);
            r = in_ready_o;
            @(posedge clk_i);
            #2;
            if (r) break;
            n++;
            if (n > 1000) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready_o stayed %b, want 1 within 1000 cycles", in_ready_o);
                break;
            end
        end
    endtask

    task automatic send_frame(input bit drop);
        for (int k = 0; k < 8; k++) send_sample(fr_idx[k], fr_dat[k]);
        if (drop) in_valid_i = 1'b0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < 8; k++) begin
            fr_idx[k] = 3'(k);
            fr_dat[k] = rnd_word();
        end
    endtask

    task automatic wait_outputs(input int target, input int bound);
        int n;
        n = 0;
        while (obs_q.size() < target && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (obs_q.size() < target) begin
            errors++;
            $display("FAIL drain_timeout: got %0d outputs, want %0d", obs_q.size(), target);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (2) step();
        checks++;
        if ({in_ready_o, out_valid_o, out_last_o} !== 3'b100) begin
            errors++;
            $display("FAIL reset_hs: ready/valid/last %b, want 100", {in_ready_o, out_valid_o, out_last_o});
        end
        checks++;
        if (out_idx_o !== 3'd0 || out_data_o !== '0) begin
            errors++;
            $display("FAIL reset_data: idx %0d data %h, want 0 0", out_idx_o, out_data_o);
        end
        checks++;
        if (frame_cnt_o !== 8'd0 || seq_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: frame_cnt %0d seq_err %b, want 0 0", frame_cnt_o, seq_err_o);
        end
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_single_frame();
        int re_tab [8] = '{0, 64, 32, 96, 16, 80, 48, 112};
        logic [W-1:0] want;
        int n0;
        ready_mode = 1;
        step();
        n0 = obs_q.size();
        for (int k = 0; k < 8; k++) begin
            fr_idx[k] = 3'(k);
            fr_dat[k] = {CW'(k * 16), CW'(-k)};
        end
        send_frame(1'b1);
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_latency0: out_valid %b at accept edge, want 0", out_valid_o);
        end
        step();
        checks++;
        if (out_valid_o !== 1'b1 || out_idx_o !== 3'd0) begin
            errors++;
            $display("FAIL single_latency1: valid %b idx %0d one cycle later, want 1 0", out_valid_o, out_idx_o);
        end
        wait_outputs(n0 + 8, 100);
        for (int k = 0; k < 8 && n0 + k < obs_q.size(); k++) begin
            want = {CW'(re_tab[k]), CW'(-(re_tab[k] / 16))};
            checks++;
            if (obs_q[n0+k].d0 !== want || obs_q[n0+k].idx !== 3'(k) || obs_q[n0+k].last !== (k == 7)) begin
                errors++;
                $display("FAIL single_bin%0d: idx %0d data %h last %b, want idx %0d data %h last %b",
                         k, obs_q[n0+k].idx, obs_q[n0+k].d0, obs_q[n0+k].last, k, want, k == 7);
            end
        end
        checks++;
        if (frame_cnt_o !== 8'd1 || seq_err_o !== 1'b0 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_end: frame_cnt %0d seq_err %b valid %b, want 1 0 0",
                     frame_cnt_o, seq_err_o, out_valid_o);
        end
    endtask

    task automatic test_shift();
        logic signed [CW-1:0] a, b, ea, eb;
        int n0;
        a = -5; b = 7; ea = -2; eb = 1;
        ready_mode = 1;
        n0 = obs_q.size();
        fill_random();
        fr_dat[0] = {a, b};
        send_frame(1'b1);
        wait_outputs(n0 + 8, 100);
        if (obs_q.size() > n0) begin
            checks++;
            if (obs_q[n0].d1 !== {ea, eb}) begin
                errors++;
                $display("FAIL shift2_bin0: data %h, want %h", obs_q[n0].d1, {ea, eb});
            end
            checks++;
            if (obs_q[n0].d0 !== {a, b}) begin
                errors++;
                $display("FAIL shift0_bin0: data %h, want %h", obs_q[n0].d0, {a, b});
            end
        end
    endtask

    task automatic test_seq_err();
        logic [2:0] order [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd5, 3'd6, 3'd7};
        int n0;
        ready_mode = 1;
        n0 = obs_q.size();
        for (int k = 0; k < 8; k++) begin
            send_sample(order[k], rnd_word());
            if (k == 2) begin
                checks++;
                if (seq_err_o !== 1'b0) begin
                    errors++;
                    $display("FAIL seq_err_early: seq_err %b after idx 2, want 0", seq_err_o);
                end
            end
            if (k == 3) begin
                checks++;
                if (seq_err_o !== 1'b1) begin
                    errors++;
                    $display("FAIL seq_err_set: seq_err %b after idx 4, want 1", seq_err_o);
                end
            end
        end
        in_valid_i = 1'b0;
        wait_outputs(n0 + 8, 100);
        clr_err_i = 1'b1;
        step();
        clr_err_i = 1'b0;
        checks++;
        if (seq_err_o !== 1'b0) begin
            errors++;
            $display("FAIL seq_err_clear: seq_err %b, want 0", seq_err_o);
        end
        // Clear coincides with a fresh mismatch: the set must win.
        clr_err_i = 1'b1;
        send_sample(3'd1, rnd_word());
        clr_err_i = 1'b0;
        checks++;
        if (seq_err_o !== 1'b1) begin
            errors++;
            $display("FAIL seq_err_set_wins: seq_err %b, want 1", seq_err_o);
        end
        send_sample(3'd0, rnd_word());
        for (int k = 2; k < 8; k++) send_sample(3'(k), rnd_word());
        in_valid_i = 1'b0;
        wait_outputs(n0 + 16, 100);
        for (int i = n0; i < obs_q.size(); i++) begin
            checks++;
            if (i >= exp_q.size() || obs_q[i].d0 !== exp_q[i].d0 || obs_q[i].idx !== 3'(i % 8)) begin
                errors++;
                $display("FAIL seq_bin%0d: idx %0d data %h, want idx %0d data %h",
                         i, obs_q[i].idx, obs_q[i].d0, i % 8, exp_q[i].d0);
            end
        end
        clr_err_i = 1'b1;
        step();
        clr_err_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n0, bad;
        logic [7:0] fc0;
        ready_mode = 0;
        step();
        step();
        n0  = obs_q.size();
        fc0 = frame_cnt_o;
        fill_random();
        send_frame(1'b0);
        fill_random();
        send_frame(1'b1);
        checks++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || out_idx_o !== 3'd0) begin
            errors++;
            $display("FAIL b2b_full: in_ready %b valid %b idx %0d, want 0 1 0", in_ready_o, out_valid_o, out_idx_o);
        end
        fill_random();
        fork
            send_frame(1'b1);
            begin
                repeat (3) step();
                checks++;
                if (in_ready_o !== 1'b0 || out_idx_o !== 3'd0) begin
                    errors++;
                    $display("FAIL b2b_stall: in_ready %b idx %0d, want 0 0", in_ready_o, out_idx_o);
                end
                ready_mode = 1;
            end
        join
        wait_outputs(n0 + 24, 200);
        bad = 0;
        for (int i = 0; i < 16 && n0 + i < obs_q.size(); i++)
            if (obs_q[n0+i].cyc != obs_q[n0].cyc + i) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_contiguous: %0d gaps in first 16 outputs, want 0", bad);
        end
        for (int i = n0; i < obs_q.size(); i++) begin
            checks++;
            if (i >= exp_q.size() || obs_q[i].d0 !== exp_q[i].d0 || obs_q[i].d1 !== exp_q[i].d1 ||
                obs_q[i].idx !== 3'(i % 8) || obs_q[i].last !== (i % 8 == 7)) begin
                errors++;
                $display("FAIL b2b_bin%0d: idx %0d data %h last %b, want idx %0d data %h last %b",
                         i, obs_q[i].idx, obs_q[i].d0, obs_q[i].last, i % 8, exp_q[i].d0, i % 8 == 7);
            end
        end
        checks++;
        if (frame_cnt_o !== fc0 + 8'd3) begin
            errors++;
            $display("FAIL b2b_frames: frame_cnt %0d, want %0d", frame_cnt_o, fc0 + 8'd3);
        end
    endtask

    task automatic test_random_ready();
        int n0;
        logic [7:0] fc0;
        ready_mode = 2;
        n0  = obs_q.size();
        fc0 = frame_cnt_o;
        for (int f = 0; f < 10; f++) begin
            fill_random();
            send_frame(1'b1);
            repeat ($urandom_range(0, 3)) step();
        end
        wait_outputs(n0 + 80, 3000);
        for (int i = n0; i < obs_q.size(); i++) begin
            checks++;
            if (i >= exp_q.size() || obs_q[i].d0 !== exp_q[i].d0 || obs_q[i].d1 !== exp_q[i].d1 ||
                obs_q[i].idx !== 3'(i % 8) || obs_q[i].last !== (i % 8 == 7)) begin
                errors++;
                $display("FAIL rnd_bin%0d: idx %0d data %h/%h, want idx %0d data %h/%h",
                         i, obs_q[i].idx, obs_q[i].d0, obs_q[i].d1, i % 8, exp_q[i].d0, exp_q[i].d1);
            end
        end
        checks++;
        if (obs_q.size() != n0 + 80 || stall_bad != 0 || stall_seen == 0) begin
            errors++;
            $display("FAIL rnd_stall: outputs %0d unstable %0d stalls %0d, want %0d 0 >0",
                     obs_q.size() - n0, stall_bad, stall_seen, 80);
        end
        checks++;
        if (ctrl_diff != 0 || frame_cnt_o !== fc0 + 8'd10) begin
            errors++;
            $display("FAIL rnd_frames: frame_cnt %0d ctrl_diff %0d, want %0d 0", frame_cnt_o, ctrl_diff, fc0 + 8'd10);
        end
    endtask

    task automatic check_frame_after_reset(input string tag);
        int n0;
        ready_mode = 1;
        n0 = obs_q.size();
        fill_random();
        send_frame(1'b1);
        wait_outputs(n0 + 8, 100);
        for (int i = n0; i < obs_q.size(); i++) begin
            checks++;
            if (i >= exp_q.size() || obs_q[i].d0 !== exp_q[i].d0 || obs_q[i].idx !== 3'(i % 8)) begin
                errors++;
                $display("FAIL %s_bin%0d: idx %0d data %h, want idx %0d data %h",
                         tag, i, obs_q[i].idx, obs_q[i].d0, i % 8, exp_q[i].d0);
            end
        end
        checks++;
        if (frame_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL %s_frames: frame_cnt %0d, want 1", tag, frame_cnt_o);
        end
    endtask

    task automatic test_reset_mid();
        ready_mode = 1;
        // Five accepts with a wrong first index so seq_err is high before reset.
        send_sample(3'd7, rnd_word());
        for (int k = 1; k < 5; k++) send_sample(3'(k), rnd_word());
        in_valid_i = 1'b0;
        rst_i = 1'b0;
        #1;
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || frame_cnt_o !== 8'd0 || seq_err_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_midframe: ready %b valid %b frame_cnt %0d seq_err %b, want 1 0 0 0",
                     in_ready_o, out_valid_o, frame_cnt_o, seq_err_o);
        end
        step();
        step();
        rst_i = 1'b1;
        step();
        check_frame_after_reset("rst_frame");

        ready_mode = 2;
        fill_random();
        send_frame(1'b1);
        wait_outputs(obs_q.size() + 3, 200);
        rst_i = 1'b0;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || out_last_o !== 1'b0 || out_idx_o !== 3'd0 || out_data_o !== '0 ||
            frame_cnt_o !== 8'd0 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_midstream: valid %b last %b idx %0d data %h frame_cnt %0d ready %b, want 0 0 0 0 0 1",
                     out_valid_o, out_last_o, out_idx_o, out_data_o, frame_cnt_o, in_ready_o);
        end
        step();
        step();
        rst_i = 1'b1;
        step();
        check_frame_after_reset("rst_stream");
    endtask

    initial begin : main
        test_reset();
        test_single_frame();
        test_shift();
        test_seq_err();
        test_back_to_back();
        test_random_ready();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_output_reorder.md
Name: fft_output_reorder

Overview:
- Sits directly downstream of the 8-point radix-2 butterfly stage.
- Accepts the butterfly's complex results one per cycle. These arrive in bit-reversed bin order and carry their index.
- Holds each 8-sample frame in a ping-pong buffer and streams it out in natural bin order (0..7) over a valid/ready interface, with an optional arithmetic down-scale.
- Input may be back-pressured only when both banks are full.

Parameters:
- CW, 25: bits per component. Sample packing is {re[2*CW-1:CW], im[CW-1:0]}, both two's complement.
- LOG2N, 3: log2 of frame length. N = 8 is the only supported value.
- SHIFT, 0: arithmetic right shift applied to each output component, range 0..4.

Ports:
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- in_data_i  in  2*CW  butterfly result {re, im}.
- in_idx_i  in  LOG2N  bit-reversed position of in_data_i (the butterfly's sample number).
- in_valid_i  in  1  in_data_i/in_idx_i valid.
- in_ready_o  out  1  block can accept a sample this cycle.
- out_data_o  out  2*CW  natural-order bin {re>>>SHIFT, im>>>SHIFT}.
- out_idx_o  out  LOG2N  natural bin number of out_data_o.
- out_valid_o  out  1  out_data_o valid.
- out_ready_i  in  1  consumer accepts out_data_o.
- out_last_o  out  1  high with bin N-1 of a frame.
- frame_cnt_o  out  8  frames fully emitted, modulo 256.
- seq_err_o  out  1  sticky: in_idx_i mismatched the expected order.
- clr_err_i  in  1  synchronous clear of seq_err_o.

Behaviour:
- Reset (rst_i=0, asynchronous) forces:
  - in_ready_o=1, out_valid_o=0, out_last_o=0, out_idx_o=0, out_data_o=0, frame_cnt_o=0, seq_err_o=0.
  - Write bank=0, read bank=0, both bank-full flags cleared, wr_cnt=0, rd_cnt=0.
  - Reset mid-frame discards all buffered data; no partial frame is ever emitted.
- Storage: two banks of N x 2*CW registers. The write pointer selects bank wb; the read pointer selects bank rb.
- Input accept: a sample is taken when in_valid_i and in_ready_o are both high.
  - It is written to bank wb at address bitrev(in_idx_i), with LOG2N bits reversed (idx 1 -> addr 4, idx 3 -> addr 6).
  - wr_cnt increments on every accept.
- Sequence check: expected in_idx_i equals wr_cnt (the butterfly emits 0..7 sequentially).
  - On mismatch, seq_err_o is set on the next edge. The sample is still written at bitrev(in_idx_i) and counted.
  - clr_err_i clears the flag. If clr_err_i coincides with a new mismatch, set wins.
- Frame complete: the accept with wr_cnt=N-1 sets full[wb], toggles wb, and wraps wr_cnt to 0.
- in_ready_o = !full[wb], registered from next-state: it drops the cycle after the second bank fills.
- Read FSM states:
  - IDLE: out_valid_o=0. Go to STREAM when full[rb]=1.
  - STREAM: out_valid_o=1, out_idx_o=rd_cnt, out_data_o = bank rb at address rd_cnt, scaled.
    - On out_ready_i, rd_cnt increments.
    - When rd_cnt=N-1 is accepted: clear full[rb], toggle rb, wrap rd_cnt to 0, increment frame_cnt_o (wrapping 255->0). Then stay in STREAM if the other bank is already full, else go to IDLE.
- out_valid_o holding: while out_valid_o=1 and out_ready_i=0, out_data_o, out_idx_o and out_last_o hold stable.
- out_last_o = out_valid_o and (rd_cnt=N-1).
- Latency: out_valid_o first rises 1 cycle after the edge that accepts the frame's last input sample. No bubbles between back-to-back frames when the next bank is full.
- Simultaneous events: the read side can release a bank on the same edge the write side completes the other bank. Both updates take effect; full flags are set and cleared per bank independently.
  - The write side never writes into a bank with full=1.
  - The freed bank becomes writable on the next cycle.
- Scaling: each component is arithmetically shifted right by SHIFT (sign-extended, truncating toward -inf); widths are unchanged. SHIFT=0 passes data bit-exact.

Test Plan:
- Single frame, in_idx 0..7 carrying re=idx*16, im=-idx, out_ready_i=1 -> out_idx 0..7 with re sequence bin k = bitrev(k)*16 (0,64,32,96,16,80,48,112) and im = -bitrev(k); out_valid rises 1 cycle after the 8th accept; out_last on bin 7; frame_cnt_o=1; seq_err_o=0.
- Three back-to-back frames, out_ready_i held 0 -> after 16 accepts in_ready_o=0 and the third frame stalls; releasing out_ready_i yields 16 contiguous outputs in order, and frame 3 is accepted once bank 0 frees; frame_cnt_o=3.
- Random out_ready_i toggling during STREAM -> out_data_o/out_idx_o stable while stalled; no bin is lost or duplicated over 10 frames (scoreboard against a reference bit-reverse model).
- in_idx sequence 0,1,2,4,3,5,6,7 -> seq_err_o=1 from the cycle after idx 4 is accepted; frame still emitted; clr_err_i pulse clears it to 0.
- SHIFT=2, input re=-5 im=7 at idx 0 -> bin 0 out re=-2, im=1.
- rst_i asserted after 5 accepts and again mid-STREAM -> all outputs reset values immediately; the next full frame emits correctly with bins starting at 0.
